// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU-side types: the machine word, the RAM model handshake state,
//   the memory arbiter state encoding and the arbiter's default constants.
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM model handshake: ACCESS marks the cycle in which ramload is valid
    // (read) or the write has been committed.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        HIT  = 2'd3
    } arb_state_t;

    localparam word_t BAD_WORD_DEFAULT       = 32'hBAD1BAD1;
    localparam int    TIMEOUT_CYCLES_DEFAULT = 16;

endpackage : cpu_types_pkg

// File: rtl/access_timer.sv
// ----------------------------------------------------------------------------
// access_timer
//   Watchdog for one RAM access. Counts cycles while enabled and raises
//   expired in the cycle where the count reaches TIMEOUT_CYCLES-1.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-high
//   clear    in   synchronous clear (takes precedence over enable)
//   enable   in   count this cycle
//   expired  out  count == TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module access_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT_CYCLES - 1));

    // Saturates at the expiry value so a stalled owner can never wrap the
    // counter back into the "not expired" range.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule : access_timer

// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
//   Serves instruction-fetch and data requests from the datapath onto a
//   single-port RAM. Data requests have strict priority. Each completed
//   access returns a one-cycle ihit/dhit pulse with registered load data,
//   followed by a mandatory HIT cycle so a still-held request is not
//   re-issued. A watchdog forces completion with BAD_WORD and sets merr.
//
// Ports:
//   CLK       in   clock, rising edge
//   nRST      in   asynchronous reset, active-high (name kept from codebase)
//   iREN      in   instruction read request, held until ihit
//   iaddr     in   instruction address
//   dREN      in   data read request, held until dhit
//   dWEN      in   data write request, held until dhit (wins over dREN)
//   daddr     in   data address
//   dstore    in   data write value
//   ihit      out  one-cycle pulse: instruction access complete
//   iload     out  fetched instruction, held after ihit
//   dhit      out  one-cycle pulse: data access complete
//   dload     out  read data, held after dhit
//   ramREN    out  RAM read strobe
//   ramWEN    out  RAM write strobe
//   ramaddr   out  RAM address (latched at request acceptance)
//   ramstore  out  RAM write data (latched at request acceptance)
//   ramload   in   RAM read data
//   ramstate  in   RAM handshake state
//   merr      out  sticky error: timeout or ramstate ERROR seen
// ----------------------------------------------------------------------------
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter word_t BAD_WORD       = BAD_WORD_DEFAULT
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      merr
);

    arb_state_t state;
    logic       op_write;   // latched data op: 1 = write, 0 = read
    logic       in_access;
    logic       expired;
    logic       d_req;

    assign d_req     = dREN | dWEN;
    assign in_access = (state == DACC) || (state == IACC);

    // Strobes are a pure decode of registered state, so they are glitch-free
    // and drop together with the state on an asynchronous reset.
    assign ramREN = (state == IACC) || ((state == DACC) && !op_write);
    assign ramWEN = (state == DACC) && op_write;

    // Cleared whenever no access is in flight, so every access starts at 0.
    access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (CLK),
        .rst     (nRST),
        .clear   (!in_access),
        .enable  (in_access),
        .expired (expired)
    );

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state    <= IDLE;
            op_write <= 1'b0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            ramaddr  <= '0;
            ramstore <= '0;
            merr     <= 1'b0;
        end else begin
            // NOTE: hits default low every cycle; only a completing transition
            // raises one, which makes them single-cycle pulses by construction.
            ihit <= 1'b0;
            dhit <= 1'b0;

            case (state)
                IDLE: begin
                    if (d_req) begin
                        ramaddr  <= daddr;
                        ramstore <= dstore;
                        op_write <= dWEN;
                        state    <= DACC;
                    end else if (iREN) begin
                        ramaddr <= iaddr;
                        state   <= IACC;
                    end
                end

                DACC: begin
                    if (ramstate == ACCESS) begin
                        if (!op_write) begin
                            dload <= ramload;
                        end
                        dhit  <= 1'b1;
                        state <= HIT;
                    end else if ((ramstate == ERROR) || expired) begin
                        dload <= BAD_WORD;
                        dhit  <= 1'b1;
                        merr  <= 1'b1;
                        state <= HIT;
                    end else if (!d_req) begin
                        state <= IDLE;
                    end
                end

                IACC: begin
                    if (ramstate == ACCESS) begin
                        iload <= ramload;
                        ihit  <= 1'b1;
                        state <= HIT;
                    end else if ((ramstate == ERROR) || expired) begin
                        iload <= BAD_WORD;
                        ihit  <= 1'b1;
                        merr  <= 1'b1;
                        state <= HIT;
                    end else if (!iREN) begin
                        state <= IDLE;
                    end
                end

                // Requests are ignored here: the requester only drops its
                // request after seeing the hit, so IDLE must not see it yet.
                HIT: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule : memory_arbiter

// File: tb/tb_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_arbiter
//   Directed self-checking bench for memory_arbiter. Inputs change and outputs
//   are sampled 1 ns after each rising edge ("cycle k" = the interval after
//   edge k). The bench plays the RAM model by driving ramstate/ramload.
// ----------------------------------------------------------------------------
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      ihit, dhit;
    word_t     iload, dload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      merr;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(
        .TIMEOUT_CYCLES(16),
        .BAD_WORD      (32'hBAD1BAD1)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ihit     (ihit),
        .iload    (iload),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .merr     (merr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b1;
        tick();
        tick();
        tests++;
        if ({ihit, dhit, ramREN, ramWEN, merr} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, want 00000", {ihit, dhit, ramREN, ramWEN, merr});
        end
        tests++;
        if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin
            fails++;
            $display("FAIL reset_words: got %h %h %h %h, want all zero", iload, dload, ramaddr, ramstore);
        end
        nRST = 1'b0;
        tick();
    endtask

    // Fetch with immediate ACCESS: strobe at N+1, hit at N+2, gone at N+3.
    task automatic test_fetch();
        iREN = 1'b1; iaddr = 32'h0000_0040;
        ramstate = ACCESS; ramload = 32'h3401_0005;
        tick();                                  // N+1
        tests++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
            fails++;
            $display("FAIL fetch_strobe: ren=%b wen=%b addr=%h, want 1 0 00000040", ramREN, ramWEN, ramaddr);
        end
        tests++;
        if (ihit !== 1'b0) begin
            fails++;
            $display("FAIL fetch_early_hit: ihit=%b, want 0", ihit);
        end
        tick();                                  // N+2
        tests++;
        if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h3401_0005) begin
            fails++;
            $display("FAIL fetch_hit: ihit=%b dhit=%b iload=%h, want 1 0 34010005", ihit, dhit, iload);
        end
        tests++;
        if (ramREN !== 1'b0) begin
            fails++;
            $display("FAIL fetch_hit_strobe: ramREN=%b, want 0", ramREN);
        end
        idle_inputs();
        tick();                                  // N+3
        tests++;
        if (ihit !== 1'b0 || iload !== 32'h3401_0005) begin
            fails++;
            $display("FAIL fetch_after: ihit=%b iload=%h, want 0 34010005", ihit, iload);
        end
    endtask

    // Simultaneous fetch + write: write first, then the held fetch.
    task automatic test_priority();
        iREN = 1'b1; iaddr = 32'h0000_0044;
        dWEN = 1'b1; daddr = 32'h0000_0080; dstore = 32'hDEAD_BEEF;
        ramstate = ACCESS; ramload = 32'h0000_1111;
        tick();                                  // N+1
        tests++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL prio_write: wen=%b ren=%b addr=%h store=%h, want 1 0 00000080 deadbeef",
                     ramWEN, ramREN, ramaddr, ramstore);
        end
        tick();                                  // N+2
        tests++;
        if (dhit !== 1'b1 || ihit !== 1'b0) begin
            fails++;
            $display("FAIL prio_dhit: dhit=%b ihit=%b, want 1 0", dhit, ihit);
        end
        tests++;
        if (dload !== 32'h0) begin
            fails++;
            $display("FAIL prio_write_dload: dload=%h, want 00000000", dload);
        end
        dWEN = 1'b0;
        tick();                                  // N+3: back in IDLE
        tests++;
        if (ramREN !== 1'b0 || dhit !== 1'b0) begin
            fails++;
            $display("FAIL prio_idle: ren=%b dhit=%b, want 0 0", ramREN, dhit);
        end
        ramload = 32'h2222_0044;
        tick();                                  // N+4: fetch in flight
        tests++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
            fails++;
            $display("FAIL prio_fetch_strobe: ren=%b addr=%h, want 1 00000044", ramREN, ramaddr);
        end
        tick();                                  // N+5
        tests++;
        if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h2222_0044) begin
            fails++;
            $display("FAIL prio_ihit: ihit=%b dhit=%b iload=%h, want 1 0 22220044", ihit, dhit, iload);
        end
        idle_inputs();
        tick();
    endtask

    // Read with three BUSY cycles before ACCESS.
    task automatic test_busy_read();
        int hits = 0;
        dREN = 1'b1; daddr = 32'h0000_0100; ramstate = BUSY;
        for (int k = 0; k < 3; k++) begin
            tick();                              // N+1..N+3
            hits += int'(dhit);
            tests++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin
                fails++;
                $display("FAIL busy_strobe[%0d]: ren=%b addr=%h, want 1 00000100", k, ramREN, ramaddr);
            end
        end
        ramstate = ACCESS; ramload = 32'h1234_5678;
        tick();                                  // N+4
        hits += int'(dhit);
        tests++;
        if (dhit !== 1'b1 || dload !== 32'h1234_5678) begin
            fails++;
            $display("FAIL busy_hit: dhit=%b dload=%h, want 1 12345678", dhit, dload);
        end
        dREN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            hits += int'(dhit);
        end
        tests++;
        if (hits != 1) begin
            fails++;
            $display("FAIL busy_hit_count: got %0d, want 1", hits);
        end
        idle_inputs();
    endtask

    // Read with RAM stuck BUSY: forced completion after 16 access cycles.
    task automatic test_timeout();
        dREN = 1'b1; daddr = 32'h0000_0104; ramstate = BUSY;
        for (int k = 1; k <= 16; k++) begin
            tick();                              // N+1..N+16
            tests++;
            if (dhit !== 1'b0 || ramREN !== 1'b1 || merr !== 1'b0) begin
                fails++;
                $display("FAIL timeout_wait[%0d]: dhit=%b ren=%b merr=%b, want 0 1 0", k, dhit, ramREN, merr);
            end
        end
        tick();                                  // N+17
        tests++;
        if (dhit !== 1'b1 || dload !== 32'hBAD1_BAD1 || merr !== 1'b1) begin
            fails++;
            $display("FAIL timeout_hit: dhit=%b dload=%h merr=%b, want 1 bad1bad1 1", dhit, dload, merr);
        end
        dREN = 1'b0;
        tick();
        // Successful read afterwards must not clear merr.
        dREN = 1'b1; daddr = 32'h0000_0108; ramstate = ACCESS; ramload = 32'h0BAD_F00D;
        tick();
        tick();
        tests++;
        if (dhit !== 1'b1 || dload !== 32'h0BAD_F00D || merr !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: dhit=%b dload=%h merr=%b, want 1 0badf00d 1", dhit, dload, merr);
        end
        idle_inputs();
        tick();
    endtask

    // Requester gives up before ACCESS: no hit, strobe drops, merr untouched.
    task automatic test_abort();
        int hits = 0;
        nRST = 1'b1;
        tick();
        nRST = 1'b0;
        dREN = 1'b1; daddr = 32'h0000_0110; ramstate = BUSY;
        tick();                                  // N+1
        tick();                                  // N+2
        tests++;
        if (ramREN !== 1'b1) begin
            fails++;
            $display("FAIL abort_strobe: ren=%b, want 1", ramREN);
        end
        dREN = 1'b0;
        tick();                                  // N+3
        hits += int'(dhit);
        tests++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            fails++;
            $display("FAIL abort_drop: ren=%b wen=%b, want 0 0", ramREN, ramWEN);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            hits += int'(dhit);
        end
        tests++;
        if (hits != 0 || merr !== 1'b0 || ramREN !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet: hits=%0d merr=%b ren=%b, want 0 0 0", hits, merr, ramREN);
        end
        idle_inputs();
    endtask

    // ramstate ERROR, then a reset in the middle of a write, then a fetch.
    task automatic test_error_and_reset();
        dREN = 1'b1; daddr = 32'h0000_0200; ramstate = ERROR;
        tick();
        tick();
        tests++;
        if (dhit !== 1'b1 || dload !== 32'hBAD1_BAD1 || merr !== 1'b1) begin
            fails++;
            $display("FAIL error_hit: dhit=%b dload=%h merr=%b, want 1 bad1bad1 1", dhit, dload, merr);
        end
        dREN = 1'b0;
        tick();
        dWEN = 1'b1; daddr = 32'h0000_0300; dstore = 32'h0000_0055; ramstate = BUSY;
        tick();
        tests++;
        if (ramWEN !== 1'b1 || merr !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: wen=%b merr=%b, want 1 1", ramWEN, merr);
        end
        #2 nRST = 1'b1;
        #1;
        tests++;
        if (ramWEN !== 1'b0 || dhit !== 1'b0 || merr !== 1'b0 || ramaddr !== 32'h0 || dload !== 32'h0) begin
            fails++;
            $display("FAIL midreset_async: wen=%b dhit=%b merr=%b addr=%h dload=%h, want 0 0 0 0 0",
                     ramWEN, dhit, merr, ramaddr, dload);
        end
        tick();
        nRST = 1'b0;
        dWEN = 1'b0;
        iREN = 1'b1; iaddr = 32'h0000_0060; ramstate = ACCESS; ramload = 32'hCAFE_0001;
        tick();                                  // N+1
        tests++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h60 || ihit !== 1'b0) begin
            fails++;
            $display("FAIL postreset_strobe: ren=%b addr=%h ihit=%b, want 1 00000060 0", ramREN, ramaddr, ihit);
        end
        tick();                                  // N+2
        tests++;
        if (ihit !== 1'b1 || iload !== 32'hCAFE_0001 || merr !== 1'b0) begin
            fails++;
            $display("FAIL postreset_hit: ihit=%b iload=%h merr=%b, want 1 cafe0001 0", ihit, iload, merr);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_busy_read();
        test_timeout();
        test_abort();
        test_error_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_memory_arbiter

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder side of the datapath memory-request interface driven by the control unit (iREN, dREN from MemRead, dWEN from MemWr).
- Arbitrates the instruction-fetch and data requests onto the single-port RAM and returns one-cycle ihit/dhit pulses with registered load data.
- Sits between the datapath/control unit and the RAM model.
- A watchdog counter bounds each RAM access.

Parameters:
TIMEOUT_CYCLES, 16, cycles in an access state without RAM ACCESS before forced completion with error
BAD_WORD, 32'hBAD1BAD1, load value returned on timeout

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous reset, active-high (asserted when 1); port name kept per codebase
iREN  in  1  instruction read request, held until ihit
iaddr  in  32  instruction address
dREN  in  1  data read request, held until dhit
dWEN  in  1  data write request, held until dhit
daddr  in  32  data address
dstore  in  32  data write value
ihit  out  1  one-cycle pulse: instruction access complete
iload  out  32  fetched instruction, valid while ihit=1, held afterwards
dhit  out  1  one-cycle pulse: data access complete
dload  out  32  read data, valid while dhit=1, held afterwards
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  cpu_types_pkg ramstate_t: FREE, BUSY, ACCESS, ERROR
merr  out  1  sticky error flag: timeout or ramstate ERROR seen

Behaviour:
- Reset while nRST=1:
  - state=IDLE; ihit, dhit, ramREN, ramWEN, merr = 0.
  - iload, dload, ramaddr, ramstore = 0; timer = 0.
  - Reset mid-access aborts immediately; no hit is issued.
- States: IDLE, DACC, IACC, HIT.
- IDLE:
  - If dREN|dWEN: latch daddr, dstore and the op (write if dWEN, else read) -> DACC.
  - Else if iREN: latch iaddr -> IACC.
  - Data has strict priority; both pending on the same cycle -> DACC.
- dREN and dWEN both high: treated as a write; ramREN=0.
- DACC/IACC:
  - Strobes and ramaddr/ramstore are driven from latched registers, decoded from state; exactly one of ramREN/ramWEN is high.
  - ramstate==ACCESS: capture ramload into dload (DACC read) or iload (IACC); set the matching hit -> HIT.
  - Writes leave dload unchanged.
  - ramstate==ERROR: set merr; complete as for a timeout.
  - Requester deasserts its request before ACCESS: abort, strobes drop next cycle, no hit -> IDLE.
  - timer increments each cycle in DACC/IACC and clears on entry.
  - timer==TIMEOUT_CYCLES-1 without ACCESS: load BAD_WORD, pulse the hit, set merr -> HIT.
- HIT:
  - Exactly one hit is high for this single cycle; strobes are 0; requests are ignored.
  - Next state is IDLE. This prevents re-issuing a request the datapath has not yet dropped.
- Latency:
  - Request seen in IDLE at cycle N: strobes high in N+1.
  - With ACCESS at N+1, hit is high in N+2.
  - Next request accepted no earlier than N+3.
- Hits are never simultaneous; at most one access is outstanding.
- merr clears only on reset.

Decomposition:
- cpu_types_pkg:
  - arb_state_t enum (IDLE, DACC, IACC, HIT).
  - Existing word_t and ramstate_t are reused.
  - BAD_WORD default constant.
- One sub-module: access_timer.
  - Ports: clear, enable, expired.
  - Parameterised by TIMEOUT_CYCLES; width $clog2(TIMEOUT_CYCLES)+1.

Test Plan:
1. iREN=1, iaddr=32'h0000_0040, ramstate=ACCESS immediately, ramload=32'h3401_0005 -> ramREN=1 with ramaddr=32'h40 at N+1; ihit=1 and iload=32'h3401_0005 at N+2; ihit=0 at N+3.
2. iREN=1 and dWEN=1 on the same cycle, daddr=32'h80, dstore=32'hDEAD_BEEF -> write served first: ramWEN=1, ramstore=32'hDEADBEEF, dhit pulses. Then, with iREN still held, IACC begins after HIT and ihit follows.
3. dREN=1, daddr=32'h100, ramstate=BUSY for 3 cycles then ACCESS with ramload=32'h1234_5678 -> dhit exactly once, dload=32'h12345678; ramREN stays high through the BUSY cycles.
4. dREN=1, ramstate held BUSY for 20 cycles, TIMEOUT_CYCLES=16 -> dhit after 16 access cycles, dload=32'hBAD1BAD1, merr=1 and stays 1 after later successful accesses.
5. dREN=1, ramstate BUSY, then dREN drops after 2 cycles -> no dhit; ramREN=0 the following cycle; state returns to IDLE; merr=0.
6. nRST asserted during DACC with ramWEN=1 -> ramWEN, dhit and merr go 0 asynchronously. After release with iREN=1, a normal fetch completes with first hit at N+2.
